// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad (Pmod KYPD layout). One active-low column is driven
// at a time for SCAN_DIV cycles. The active-low rows are sampled at the end of
// each column dwell. A full four-column scan yields one result: NONE, KEY(code)
// or MULTI. Each new result must repeat DEBOUNCE_SCANS times before the press
// or release is accepted. Each accepted key is reported once as a hex code
// with a one-cycle strobe.
//
// Parameters
//   SCAN_DIV        cycles each column is driven (4..65535)
//   DEBOUNCE_SCANS  identical consecutive scans needed to accept (1..15)
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   row[3:0]   in   keypad rows, active-low, asynchronous to clk
//   col[3:0]   out  column drive, active-low one-hot
//   key_code   out  hex code of the last accepted key
//   key_valid  out  one-cycle pulse when key_code is updated
//   key_down   out  high while an accepted key is held
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } result_kind_e;

  typedef struct packed {
    result_kind_e kind;
    logic [3:0]   code;  // meaningful only for RES_KEY, kept 0 otherwise
  } scan_result_t;

  typedef enum logic {
    RELEASED,
    PRESSED
  } state_e;

  localparam logic [15:0]  DIV_LAST    = 16'(SCAN_DIV - 1);
  localparam logic [3:0]   DEB_MAX     = 4'(DEBOUNCE_SCANS);
  localparam scan_result_t RESULT_NONE = '{kind: RES_NONE, code: 4'h0};

  // Nibble {row, col} of this table is the key legend at that matrix position.
  localparam logic [63:0] KEY_TABLE = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[4 * {r, c} +: 4];
  endfunction

  // ---------------------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Dwell divider and column index
  // ---------------------------------------------------------------------------
  logic [15:0] div;
  logic [1:0]  idx;
  logic        tc;
  logic        scan_done;

  assign tc        = (div == DIV_LAST);
  assign scan_done = tc && (idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (tc) begin
      div <= '0;
      idx <= idx + 2'd1;  // 3 wraps to 0
    end else begin
      div <= div + 16'd1;
    end
  end

  // Driven straight from the index register, so only one column is ever low.
  assign col = ~(4'b0001 << idx);

  // ---------------------------------------------------------------------------
  // Current-column decode and per-scan accumulation
  // ---------------------------------------------------------------------------
  logic [2:0]   col_cnt;
  logic [3:0]   col_code;
  logic [1:0]   acc_cnt;
  logic [3:0]   acc_code;
  logic [2:0]   sum;
  logic [1:0]   scan_cnt;
  logic [3:0]   scan_code;
  scan_result_t scan_result;

  // NOTE: every combinational output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    col_cnt  = '0;
    col_code = '0;
    // Walk from the highest row down so the lowest low row's code is kept.
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        col_cnt  = col_cnt + 3'd1;
        col_code = key_map(2'(r), idx);
      end
    end
  end

  always_comb begin
    sum       = {1'b0, acc_cnt} + col_cnt;
    scan_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    // Earlier columns take priority for the first key found.
    scan_code = (acc_cnt == 2'd0) ? col_code : acc_code;
    scan_result = RESULT_NONE;
    if (scan_cnt == 2'd1) begin
      scan_result = '{kind: RES_KEY, code: scan_code};
    end else if (scan_cnt == 2'd2) begin
      scan_result.kind = RES_MULTI;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (tc) begin
      if (idx == 2'd3) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= scan_cnt;
        acc_code <= scan_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce over whole scans
  // ---------------------------------------------------------------------------
  scan_result_t prev_result;
  logic [3:0]   deb_cnt;
  logic [3:0]   deb_next;
  logic         same_result;
  logic         deb_hit;  // one-cycle flag: counter just reached DEB_MAX

  always_comb begin
    same_result = (scan_result == prev_result);
    if (same_result) begin
      deb_next = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 4'd1;
    end else begin
      deb_next = 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_result <= RESULT_NONE;
      deb_cnt     <= '0;
      deb_hit     <= 1'b0;
    end else begin
      deb_hit <= 1'b0;
      if (scan_done) begin
        prev_result <= scan_result;
        deb_cnt     <= deb_next;
        // A counter already saturated on the same result is not a new arrival.
        deb_hit     <= (deb_next == DEB_MAX) && (!same_result || deb_cnt != DEB_MAX);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press / release state machine
  // ---------------------------------------------------------------------------
  state_e     state;
  state_e     state_next;
  logic [3:0] code_next;
  logic       valid_next;

  always_comb begin
    state_next = state;
    code_next  = key_code;
    valid_next = 1'b0;
    if (deb_hit) begin
      unique case (state)
        RELEASED: begin
          if (prev_result.kind == RES_KEY) begin
            code_next  = prev_result.code;
            valid_next = 1'b1;
            state_next = PRESSED;
          end
        end
        PRESSED: begin
          if (prev_result.kind == RES_KEY && prev_result.code != key_code) begin
            // Roll-over straight onto another key.
            code_next  = prev_result.code;
            valid_next = 1'b1;
          end else if (prev_result.kind == RES_NONE) begin
            state_next = RELEASED;
          end
        end
        default: state_next = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RELEASED;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      key_code  <= code_next;
      key_valid <= valid_next;
    end
  end

  assign key_down = (state == PRESSED);

endmodule
